// File: rtl/matrix_result_drain_pkg.sv
// Shared matrix constants used by matrix_mul and its result drain stage.
// The package keeps the historical name matrix_pkg so both blocks import it
// the same way.
package matrix_pkg;

   localparam int ROW       = 3;
   localparam int COL       = 3;
   localparam int NUM       = 3;
   localparam int MAT_ELEMS = ROW * COL;

   localparam int DEF_DATA_W = 8;
   localparam int ELEM_W     = 2 * DEF_DATA_W;

   // Row-major element index: k = COL*row + col.
   function automatic int elem_k(input int row, input int col);
      return (COL * row) + col;
   endfunction

endpackage

// File: rtl/matrix_result_drain_if.sv
// Capture and streaming signals of the result drain stage.
// "master" is the drain side (it sources the element stream),
// "slave" is the surrounding environment (producer strobe + consumer).
interface matrix_result_drain_if
   import matrix_pkg::*;
   #(parameter int DATA_W = DEF_DATA_W) ();

   logic [2*DATA_W*MAT_ELEMS-1:0] din_C;
   logic                          in_vld;
   logic [2*DATA_W-1:0]           dout;
   logic [3:0]                    dout_idx;
   logic                          dout_last;
   logic                          dout_vld;
   logic                          dout_rdy;
   logic                          ovf;
   logic                          ovf_clr;

   modport master (
      input  din_C, in_vld, dout_rdy, ovf_clr,
      output dout, dout_idx, dout_last, dout_vld, ovf
   );

   modport slave (
      output din_C, in_vld, dout_rdy, ovf_clr,
      input  dout, dout_idx, dout_last, dout_vld, ovf
   );

endinterface

// File: rtl/matrix_result_drain.sv
// Result drain for matrix_mul: a two-entry result buffer that absorbs a
// full 3x3 result while the previous one drains element by element
// (row-major) over valid/ready. matrix_mul cannot be stalled, so a result
// arriving with both entries occupied is dropped and flagged in ovf.
module matrix_result_drain
   import matrix_pkg::*;
   #(parameter int DATA_W = DEF_DATA_W) (
   input logic                  clk,
   input logic                  rst,
   matrix_result_drain_if.master bus
);

   localparam int EW = 2 * DATA_W;
   localparam int MW = EW * MAT_ELEMS;

   // Occupancy encodings (cnt_r doubles as the state register).
   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_FULL  = 2'd2;

   localparam logic [3:0] IDX_LAST = 4'd8;

   logic [MW-1:0] buf_r [2];
   logic          wr_ptr_r;
   logic          rd_ptr_r;
   logic [3:0]    idx_r;
   logic [1:0]    cnt_r;
   logic          ovf_r;

   logic          vld_s;
   logic          pop_s;
   logic          last_pop_s;
   logic          cap_s;
   logic          drop_s;
   logic [MW-1:0] cur_mat_s;

   // Handshake decode: a capture may reuse the entry freed by a same-cycle last-pop.
   always_comb begin
      vld_s      = (cnt_r != ST_EMPTY);
      pop_s      = vld_s & bus.dout_rdy;
      last_pop_s = pop_s & (idx_r == IDX_LAST);
      cap_s      = bus.in_vld & ((cnt_r != ST_FULL) | last_pop_s);
      drop_s     = bus.in_vld & ~cap_s;
   end

   // Result storage: write the incoming matrix into the entry at wr_ptr.
   always_ff @(posedge clk) begin
      if (rst) begin
         buf_r[0] <= '0;
         buf_r[1] <= '0;
      end else if (cap_s) begin
         buf_r[wr_ptr_r] <= bus.din_C;
      end else begin
         buf_r[wr_ptr_r] <= buf_r[wr_ptr_r];
      end
   end

   // Write pointer advances on every accepted capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= 1'b0;
      end else if (cap_s) begin
         wr_ptr_r <= ~wr_ptr_r;
      end else begin
         wr_ptr_r <= wr_ptr_r;
      end
   end

   // Read side: element index walks 0..8, read pointer flips after element 8.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx_r    <= 4'd0;
         rd_ptr_r <= 1'b0;
      end else if (last_pop_s) begin
         idx_r    <= 4'd0;
         rd_ptr_r <= ~rd_ptr_r;
      end else if (pop_s) begin
         idx_r    <= idx_r + 4'd1;
         rd_ptr_r <= rd_ptr_r;
      end else begin
         idx_r    <= idx_r;
         rd_ptr_r <= rd_ptr_r;
      end
   end

   // Occupancy: +1 on capture, -1 on last-pop, unchanged when both coincide.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r <= ST_EMPTY;
      end else begin
         case ({cap_s, last_pop_s})
            2'b10:   cnt_r <= cnt_r + 2'd1;
            2'b01:   cnt_r <= cnt_r - 2'd1;
            default: cnt_r <= cnt_r;
         endcase
      end
   end

   // Sticky overflow flag; a drop outranks a simultaneous clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_r <= 1'b0;
      end else if (drop_s) begin
         ovf_r <= 1'b1;
      end else if (bus.ovf_clr) begin
         ovf_r <= 1'b0;
      end else begin
         ovf_r <= ovf_r;
      end
   end

   // Element select from the entry being drained; idx_r never exceeds 8.
   always_comb begin
      cur_mat_s = buf_r[rd_ptr_r];
   end

   assign bus.dout      = cur_mat_s[idx_r*EW +: EW];
   assign bus.dout_idx  = idx_r;
   assign bus.dout_vld  = vld_s;
   assign bus.dout_last = vld_s & (idx_r == IDX_LAST);
   assign bus.ovf       = ovf_r;

   // ST_ONE documents the middle occupancy level of cnt_r.
   localparam logic [1:0] ST_UNUSED_ONE = ST_ONE;

endmodule

// File: tb/tb_matrix_result_drain.sv
// Scoreboard bench for matrix_result_drain. A reference model tracks the
// number of outstanding elements and decides accept/drop from buffer rules;
// accepted matrices push their nine elements into an expected queue that a
// separate monitor drains whenever the DUT shows a valid element.
module tb_matrix_result_drain;
   import matrix_pkg::*;

   localparam int DW = DEF_DATA_W;
   localparam int EW = 2 * DW;

   typedef struct {
      logic [EW-1:0] val;
      logic [3:0]    idx;
   } exp_t;

   logic clk;
   logic rst;
   matrix_result_drain_if #(.DATA_W(DW)) bus ();

   matrix_result_drain #(.DATA_W(DW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int   tests;
   int   fails;
   exp_t exp_q[$];
   int   n_m;
   logic ovf_m;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: evaluates each clock edge with the inputs held across it.
   always @(posedge clk) begin
      bit pop;
      bit lastp;
      bit cap;
      int held;
      #1;
      if (rst) begin
         n_m   = 0;
         ovf_m = 1'b0;
         exp_q.delete();
      end else begin
         pop   = (n_m > 0) && (bus.dout_rdy === 1'b1);
         lastp = pop && ((n_m % MAT_ELEMS) == 1);
         held  = (n_m + MAT_ELEMS - 1) / MAT_ELEMS;
         cap   = (bus.in_vld === 1'b1) && ((held < 2) || lastp);
         if (pop) n_m--;
         if (cap) begin
            n_m += MAT_ELEMS;
            for (int k = 0; k < MAT_ELEMS; k++) begin
               exp_t e;
               e.val = bus.din_C[k*EW +: EW];
               e.idx = 4'(k);
               exp_q.push_back(e);
            end
         end
         if ((bus.in_vld === 1'b1) && !cap) ovf_m = 1'b1;
         else if (bus.ovf_clr === 1'b1) ovf_m = 1'b0;
      end
   end

   // Monitor: compares the presented element with the queue head, pops on handshake.
   initial begin
      repeat (2) @(posedge clk);
      forever begin
         @(negedge clk);
         chk("dout_vld", 32'(bus.dout_vld), 32'(n_m != 0));
         chk("ovf", 32'(bus.ovf), 32'(ovf_m));
         if (bus.dout_vld === 1'b1) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_elem: got %0h idx %0d expected none", bus.dout, bus.dout_idx);
            end else begin
               chk("dout", 32'(bus.dout), 32'(exp_q[0].val));
               chk("dout_idx", 32'(bus.dout_idx), 32'(exp_q[0].idx));
               chk("dout_last", 32'(bus.dout_last), 32'(exp_q[0].idx == 4'd8));
               if (bus.dout_rdy === 1'b1) void'(exp_q.pop_front());
            end
         end else begin
            chk("dout_last_idle", 32'(bus.dout_last), 32'd0);
         end
      end
   end

   task automatic cycle();
      @(posedge clk);
      #2;
   endtask

   function automatic logic [EW*MAT_ELEMS-1:0] mk_mat(input logic [EW-1:0] base);
      logic [EW*MAT_ELEMS-1:0] m;
      for (int r = 0; r < ROW; r++)
         for (int c = 0; c < COL; c++)
            m[elem_k(r, c)*EW +: EW] = base + EW'(elem_k(r, c));
      return m;
   endfunction

   task automatic send(input logic [EW*MAT_ELEMS-1:0] m);
      bus.din_C  = m;
      bus.in_vld = 1'b1;
      cycle();
      bus.in_vld = 1'b0;
   endtask

   initial begin
      rst         = 1'b1;
      bus.din_C   = '0;
      bus.in_vld  = 1'b0;
      bus.dout_rdy = 1'b0;
      bus.ovf_clr = 1'b0;
      repeat (3) cycle();
      chk("rst_dout", 32'(bus.dout), 32'd0);
      chk("rst_idx", 32'(bus.dout_idx), 32'd0);
      chk("rst_vld", 32'(bus.dout_vld), 32'd0);
      chk("rst_ovf", 32'(bus.ovf), 32'd0);
      rst = 1'b0;
      cycle();

      // Single matrix, consumer always ready.
      bus.dout_rdy = 1'b1;
      send(mk_mat(16'h0100));
      repeat (12) cycle();

      // Backpressure 1,0,0 pattern.
      send(mk_mat(16'h0200));
      for (int i = 0; i < 30; i++) begin
         bus.dout_rdy = (i % 3 == 0);
         cycle();
      end
      bus.dout_rdy = 1'b1;
      repeat (5) cycle();

      // Two buffered, third dropped; then drain and clear.
      bus.dout_rdy = 1'b0;
      send(mk_mat(16'h0A00));
      cycle();
      send(mk_mat(16'h0B00));
      cycle();
      send(mk_mat(16'h0C00));
      cycle();
      chk("ovf_after_drop", 32'(bus.ovf), 32'd1);
      bus.dout_rdy = 1'b1;
      repeat (20) cycle();
      bus.ovf_clr = 1'b1;
      cycle();
      bus.ovf_clr = 1'b0;
      chk("ovf_cleared", 32'(bus.ovf), 32'd0);
      cycle();

      // Capture in the same cycle as the last-pop of A while full.
      bus.dout_rdy = 1'b0;
      send(mk_mat(16'h0A00));
      send(mk_mat(16'h0B00));
      cycle();
      bus.dout_rdy = 1'b1;
      repeat (8) cycle();
      send(mk_mat(16'h0D00));
      chk("no_ovf_sim", 32'(bus.ovf), 32'd0);
      repeat (20) cycle();

      // Reset mid-stream at dout_idx 4, then a fresh matrix.
      send(mk_mat(16'h0E00));
      repeat (4) cycle();
      chk("idx_before_rst", 32'(bus.dout_idx), 32'd4);
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      chk("vld_after_rst", 32'(bus.dout_vld), 32'd0);
      chk("ovf_after_rst", 32'(bus.ovf), 32'd0);
      send(mk_mat(16'h0F00));
      chk("fresh_idx", 32'(bus.dout_idx), 32'd0);
      repeat (12) cycle();

      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         logic [EW*MAT_ELEMS-1:0] m;
         for (int k = 0; k < MAT_ELEMS; k++) m[k*EW +: EW] = EW'($urandom_range(0, 65535));
         bus.din_C    = m;
         bus.in_vld   = ($urandom_range(0, 7) == 0);
         bus.dout_rdy = ($urandom_range(0, 9) < 7);
         bus.ovf_clr  = ($urandom_range(0, 19) == 0);
         cycle();
      end
      bus.in_vld   = 1'b0;
      bus.ovf_clr  = 1'b0;
      bus.dout_rdy = 1'b1;
      repeat (30) cycle();
      chk("leftover", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
